// File: rtl/q_sys_pio_pkg.sv
// Shared constants for the q_sys multi-channel input PIO: register offsets,
// edge-type selectors and the channel-field width helper.
package q_sys_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MASK = 2'd1,
    REG_RSVD = 2'd2,
    REG_EDGE = 2'd3
  } reg_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/q_sys_pio_in_multi_if.sv
// Avalon-MM slave bus of the multi-channel input PIO, including its level irq.
interface q_sys_pio_in_multi_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  modport master (output address, chipselect, write, read, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write, read, writedata,
                  output readdata, irq);
endinterface

// File: rtl/q_sys_pio_in_chan.sv
// One input channel: synchroniser, previous-value register, edge detect,
// sticky RW1C edge capture and interrupt mask.
module q_sys_pio_in_chan
  import q_sys_pio_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              capture_en,
  input  logic              mask_we,
  input  logic              w1c_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] sync_val,
  output logic [DATA_W-1:0] mask_val,
  output logic [DATA_W-1:0] edge_val,
  output logic              irq_or
);

  logic [DATA_W-1:0] sync_r [SYNC_STAGES];
  logic [DATA_W-1:0] prev_r;
  logic [DATA_W-1:0] mask_r;
  logic [DATA_W-1:0] edge_r;
  logic [DATA_W-1:0] event_s;
  logic [DATA_W-1:0] edge_nxt_s;

  // synchroniser chain and previous-value register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_r[SYNC_STAGES-1];

  // edge detect; clearing is applied before setting so a fresh event survives a W1C
  always_comb begin
    event_s = '0;
    case (EDGE_TYPE)
      EDGE_RISE: event_s = sync_val & ~prev_r;
      EDGE_FALL: event_s = ~sync_val & prev_r;
      EDGE_ANY:  event_s = sync_val ^ prev_r;
      default:   event_s = sync_val ^ prev_r;
    endcase
    edge_nxt_s = edge_r & ~(w1c_we ? wdata : '0);
    edge_nxt_s = edge_nxt_s | (capture_en ? event_s : '0);
  end

  // mask and capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= '0;
      edge_r <= '0;
    end else begin
      mask_r <= mask_we ? wdata : mask_r;
      edge_r <= edge_nxt_s;
    end
  end

  assign mask_val = mask_r;
  assign edge_val = edge_r;
  assign irq_or   = |(edge_r & mask_r);

endmodule

// File: rtl/q_sys_pio_in_multi.sv
// Multi-channel Avalon-MM input PIO with combined level irq.
// Optional PIO_IN_SNAPSHOT_EN: a channel-0 DATA read snapshots all channels.
module q_sys_pio_in_multi
  import q_sys_pio_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  q_sys_pio_in_multi_if.slave      bus,
  input  logic [NUM_CH*DATA_W-1:0] in_port
);

  localparam int CH_W      = ch_w(NUM_CH);
  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int CNT_W     = $clog2(PRIME_MAX + 1);

  logic [CH_W-1:0]   ch_s;
  reg_e              reg_s;
  logic              ch_ok_s;
  logic              wr_s;
  logic              capture_en_s;
  logic [CNT_W-1:0]  prime_cnt_r;
  logic [NUM_CH-1:0] mask_we_s;
  logic [NUM_CH-1:0] w1c_we_s;
  logic [NUM_CH-1:0] irq_or_s;
  logic [DATA_W-1:0] sync_s [NUM_CH];
  logic [DATA_W-1:0] mask_s [NUM_CH];
  logic [DATA_W-1:0] edge_s [NUM_CH];
  logic [DATA_W-1:0] live_s;
  logic [DATA_W-1:0] mask_rd_s;
  logic [DATA_W-1:0] edge_rd_s;
  logic [DATA_W-1:0] data_val_s;
  logic [31:0]       rd_s;
  logic [31:0]       readdata_r;
  logic              irq_r;

  assign ch_s    = bus.address[CH_W+1:2];
  assign reg_s   = reg_e'(bus.address[1:0]);
  assign ch_ok_s = (int'(ch_s) < NUM_CH);
  assign wr_s    = bus.chipselect & bus.write;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign mask_we_s[k] = wr_s && (ch_s == CH_W'(k)) && (reg_s == REG_MASK);
    assign w1c_we_s[k]  = wr_s && (ch_s == CH_W'(k)) && (reg_s == REG_EDGE);

    q_sys_pio_in_chan #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (in_port[k*DATA_W +: DATA_W]),
      .capture_en (capture_en_s),
      .mask_we    (mask_we_s[k]),
      .w1c_we     (w1c_we_s[k]),
      .wdata      (bus.writedata[DATA_W-1:0]),
      .sync_val   (sync_s[k]),
      .mask_val   (mask_s[k]),
      .edge_val   (edge_s[k]),
      .irq_or     (irq_or_s[k])
    );
  end

  if (DATA_W < 32) begin : g_unused_wd
    logic unused_wd_s;
    assign unused_wd_s = ^bus.writedata[31:DATA_W];
  end

  // Inputs already high at reset must not look like edges while the chain fills.
  assign capture_en_s = (prime_cnt_r == CNT_W'(PRIME_MAX));

  // saturating prime counter, re-armed only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_r <= '0;
    end else if (!capture_en_s) begin
      prime_cnt_r <= prime_cnt_r + CNT_W'(1);
    end else begin
      prime_cnt_r <= prime_cnt_r;
    end
  end

  // and-or channel select of live data, mask and capture
  always_comb begin
    live_s    = '0;
    mask_rd_s = '0;
    edge_rd_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      live_s    = live_s    | (sync_s[k] & {DATA_W{ch_s == CH_W'(k)}});
      mask_rd_s = mask_rd_s | (mask_s[k] & {DATA_W{ch_s == CH_W'(k)}});
      edge_rd_s = edge_rd_s | (edge_s[k] & {DATA_W{ch_s == CH_W'(k)}});
    end
  end

`ifdef PIO_IN_SNAPSHOT_EN
  logic [DATA_W-1:0] snap_r [NUM_CH];
  logic [DATA_W-1:0] snap_rd_s;
  logic              snap_we_s;

  assign snap_we_s = bus.chipselect && bus.read && (ch_s == '0) && (reg_s == REG_DATA);

  // snapshot of every channel on a channel-0 DATA read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) snap_r[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) snap_r[k] <= snap_we_s ? sync_s[k] : snap_r[k];
    end
  end

  // snapshot channel select
  always_comb begin
    snap_rd_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      snap_rd_s = snap_rd_s | (snap_r[k] & {DATA_W{ch_s == CH_W'(k)}});
    end
  end

  assign data_val_s = (ch_s == '0) ? live_s : snap_rd_s;
`else
  logic unused_read_s;
  assign unused_read_s = bus.read;
  assign data_val_s    = live_s;
`endif

  // register read mux
  always_comb begin
    rd_s = 32'h0;
    if (!ch_ok_s) begin
      rd_s = 32'h0;
    end else begin
      case (reg_s)
        REG_DATA: rd_s = 32'(data_val_s);
        REG_MASK: rd_s = 32'(mask_rd_s);
        REG_EDGE: rd_s = 32'(edge_rd_s);
        REG_RSVD: rd_s = 32'h0;
        default:  rd_s = 32'h0;
      endcase
    end
  end

  // registered readdata and irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'h0;
      irq_r      <= 1'b0;
    end else begin
      readdata_r <= rd_s;
      irq_r      <= |irq_or_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = irq_r;

endmodule

// File: tb/tb_q_sys_pio_in_multi.sv
// Directed scoreboard bench for q_sys_pio_in_multi; expects are queued when a
// transaction is driven and popped when readdata/irq is sampled.
module tb_q_sys_pio_in_multi;
  import q_sys_pio_pkg::*;

  // Five channels so that channel field 5 is a genuine out-of-range address.
  localparam int NUM_CH = 5;
  localparam int DATA_W = 10;
  localparam int CH_W   = 3;
  localparam int ADDR_W = CH_W + 2;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_CH*DATA_W-1:0] in_port;
  int                       tests = 0;
  int                       fails = 0;
  logic [31:0]              exp_q [$];
  string                    tag_q [$];

  q_sys_pio_in_multi_if #(.ADDR_W(ADDR_W)) bus ();

  q_sys_pio_in_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2), .EDGE_TYPE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] got);
    logic [31:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", got);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (got === e) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", t, got, e);
      end
    end
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push_exp(tag, {31'h0, e});
    compare({31'h0, bus.irq});
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    in_port[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_read(input logic [CH_W-1:0] ch, input logic [1:0] rg,
                         input logic [31:0] e, input string tag);
    @(negedge clk);
    bus.address    = {ch, rg};
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    push_exp(tag, e);
    @(posedge clk);
    #1;
    compare(bus.readdata);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic do_write(input logic [CH_W-1:0] ch, input logic [1:0] rg,
                          input logic [31:0] d);
    @(negedge clk);
    bus.address    = {ch, rg};
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    in_port        = '0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.writedata  = 32'h0;
    set_ch(0, 10'h3FF);
    #1;
    push_exp("reset_readdata", 32'h0);
    compare(bus.readdata);
    chk_irq("reset_irq", 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 1: input high through reset is not an edge
    do_read(3'd0, 2'd3, 32'h000, "t1_edge_ch0");
    do_read(3'd0, 2'd0, 32'h3FF, "t1_data_ch0");
    do_read(3'd0, 2'd2, 32'h000, "t1_rsvd_ch0");
    chk_irq("t1_irq", 1'b0);

    // 2: rising edge on ch2 bit4, latency, mask and W1C irq timing
    @(negedge clk);
    set_ch(2, 10'h010);
    do_read(3'd2, 2'd0, 32'h000, "t2_data_ch2_early");
    do_read(3'd2, 2'd0, 32'h010, "t2_data_ch2");
    do_read(3'd2, 2'd3, 32'h010, "t2_edge_ch2");
    chk_irq("t2_irq_masked", 1'b0);
    do_write(3'd2, 2'd1, 32'h010);
    chk_irq("t2_irq_mask_same", 1'b0);
    @(posedge clk);
    #1;
    chk_irq("t2_irq_set", 1'b1);
    do_read(3'd2, 2'd1, 32'h010, "t2_mask_ch2");
    do_write(3'd2, 2'd3, 32'h010);
    chk_irq("t2_irq_w1c_same", 1'b1);
    @(posedge clk);
    #1;
    chk_irq("t2_irq_clr", 1'b0);
    do_read(3'd2, 2'd3, 32'h000, "t2_edge_ch2_clr");

    // 3: W1C coinciding with a new capture on ch1 bit0
    @(negedge clk);
    set_ch(1, 10'h001);
    @(posedge clk);
    @(posedge clk);
    do_write(3'd1, 2'd3, 32'h001);
    do_read(3'd1, 2'd3, 32'h001, "t3_edge_ch1_kept");

    // 4: out-of-range channel reads 0, writes ignored
    do_read(3'd5, 2'd0, 32'h0, "t4_data_ch5");
    do_read(3'd5, 2'd1, 32'h0, "t4_mask_ch5");
    do_read(3'd7, 2'd3, 32'h0, "t4_edge_ch7");
    do_write(3'd5, 2'd1, 32'h3FF);
    do_write(3'd5, 2'd3, 32'h3FF);
    do_write(3'd7, 2'd1, 32'h3FF);
    do_read(3'd1, 2'd1, 32'h000, "t4_mask_ch1");
    do_read(3'd2, 2'd1, 32'h010, "t4_mask_ch2");
    do_read(3'd4, 2'd1, 32'h000, "t4_mask_ch4");
    do_read(3'd1, 2'd3, 32'h001, "t4_edge_ch1");
    chk_irq("t4_irq", 1'b0);

    // 5: snapshot behaviour (or live data in the default build)
    @(negedge clk);
    set_ch(1, 10'h055);
    repeat (4) @(posedge clk);
    #1;
    do_read(3'd0, 2'd0, 32'h3FF, "t5_data_ch0");
    @(negedge clk);
    set_ch(1, 10'h0AA);
    repeat (4) @(posedge clk);
    #1;
`ifdef PIO_IN_SNAPSHOT_EN
    do_read(3'd1, 2'd0, 32'h055, "t5_data_ch1_snap");
`else
    do_read(3'd1, 2'd0, 32'h0AA, "t5_data_ch1_live");
`endif
    do_read(3'd1, 2'd3, 32'h0FF, "t5_edge_ch1_sticky");

    // 6: reset while irq is high and a read is in flight
    do_write(3'd1, 2'd1, 32'h001);
    @(posedge clk);
    #1;
    chk_irq("t6_irq_before", 1'b1);
    @(negedge clk);
    bus.address    = {3'd1, 2'd1};
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    @(posedge clk);
    #1;
    push_exp("t6_read_before", 32'h001);
    compare(bus.readdata);
    #2;
    reset_n = 1'b0;
    #1;
    push_exp("t6_readdata_in_reset", 32'h0);
    compare(bus.readdata);
    chk_irq("t6_irq_in_reset", 1'b0);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
`ifdef PIO_IN_SNAPSHOT_EN
    do_read(3'd1, 2'd0, 32'h000, "t6_snap_cleared");
`else
    do_read(3'd1, 2'd0, 32'h0AA, "t6_data_ch1_live");
`endif
    do_read(3'd1, 2'd3, 32'h000, "t6_edge_ch1");
    do_read(3'd1, 2'd1, 32'h000, "t6_mask_ch1");
    do_read(3'd2, 2'd1, 32'h000, "t6_mask_ch2");
    do_read(3'd2, 2'd3, 32'h000, "t6_edge_ch2");
    do_read(3'd0, 2'd3, 32'h000, "t6_edge_ch0");
    chk_irq("t6_irq_after", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
